jtopll_regbank: RTL and testbench

Parametrised OPLL register bank with host bus interface. Decodes CPU address/data writes with YM2413-style wait timing into per-channel registers, a user patch and a rhythm register. Runs the channel/operator slot sequencer and presents per-slot channel and operator configuration to the PG/EG/OP pipeline. Built-in instrument and drum patches load through a programming port.

---
 rtl/jtopll_regbank_if.sv | 16 +
 rtl/jtopll_regbank.sv | 206 ++++++++++++++++++++
 tb/tb_jtopll_regbank.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtopll_regbank_if.sv
// Host bus for the OPLL register bank.
// wr   : write strobe, one clk wide (host -> bank)
// addr : 0 = address port, 1 = data port (host -> bank)
// din  : write data (host -> bank)
// busy : a write wait is pending (bank -> host)
// drop : one-clk pulse, a write arrived while busy and was ignored (bank -> host)
interface jtopll_regbank_if;
  logic       wr;
  logic       addr;
  logic [7:0] din;
  logic       busy;
  logic       drop;

  modport master (output wr, addr, din, input busy, drop);
  modport slave  (input wr, addr, din, output busy, drop);
endinterface

// File: rtl/jtopll_regbank.sv
// OPLL register bank: host write decoding with YM2413-style wait timing,
// per-channel registers, user patch 0, rhythm register, the channel/operator
// slot sequencer and per-slot operator configuration for the PG/EG/OP pipe.
// Built-in instrument and drum patches are loaded through the prog port.
//
// Ports:
//   clk, rst        clock, async active-high reset
//   cen             clock enable for sequencer and wait counter
//   bus             host bus (wr/addr/din in, busy/drop out)
//   zero            slot ch=0, op=0
//   ch, op          current slot (op 0 = modulator, 1 = carrier)
//   fnum, block, keyon, sus_en, vol, rhy_en   current channel state
//   opcfg           {am,vib,egt,ksr,mul,ksl,tl,wf,fb,ar,dr,sl,rr}
//   prog_addr/data/we  built-in patch RAM write port
//
// Host FSM:
//   state  | meaning
//   S_IDLE | ready, next write is accepted
//   S_WAIT | counting down the post-write wait on cen, writes are dropped
module jtopll_regbank #(
  parameter int CH        = 9,
  parameter int NPATCH    = 15,
  parameter int ADDR_WAIT = 12,
  parameter int DATA_WAIT = 84,
  parameter int PAW       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  jtopll_regbank_if.slave   bus,
  output logic              zero,
  output logic [3:0]        ch,
  output logic              op,
  output logic [8:0]        fnum,
  output logic [2:0]        block,
  output logic              keyon,
  output logic              sus_en,
  output logic [3:0]        vol,
  output logic              rhy_en,
  output logic [35:0]       opcfg,
  input  logic [PAW-1:0]    prog_addr,
  input  logic [7:0]        prog_data,
  input  logic              prog_we
);

  // RAM holds patches 1..NPATCH+6; patch 0 lives in resettable registers
  localparam int RAMSZ = (NPATCH + 6) * 8;
  localparam int RAW   = $clog2(RAMSZ);
  localparam int WMAX  = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
  localparam int CW    = $clog2(WMAX + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [7:0]    lat;
  logic          drop_r;

  logic [7:0] user_p [8];
  logic [8:0] fnum_r [CH];
  logic [2:0] blk_r  [CH];
  logic       key_r  [CH];
  logic       sus_r  [CH];
  logic [3:0] inst_r [CH];
  logic [3:0] vol_r  [CH];
  logic [4:0] rhy_r;          // BD, SD, TOM, CY, HH
  logic [7:0] ram    [RAMSZ];

  logic       do_wr;
  logic [3:0] chan;
  logic       chan_ok;

  assign do_wr   = bus.wr && bus.addr && (state == S_IDLE);
  assign chan    = lat[3:0];
  assign chan_ok = int'(chan) < CH;

  assign bus.busy = (state == S_WAIT);
  assign bus.drop = drop_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch <= 4'd0;
      op <= 1'b0;
    end else if (cen) begin
      op <= ~op;
      if (op) ch <= (int'(ch) == CH - 1) ? 4'd0 : ch + 4'd1;
    end
  end

  assign zero = (ch == 4'd0) && !op;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      lat    <= 8'd0;
      drop_r <= 1'b0;
    end else begin
      drop_r <= bus.wr && (state == S_WAIT);
      case (state)
        S_IDLE: begin
          if (bus.wr) begin
            state <= S_WAIT;
            if (!bus.addr) begin
              lat <= bus.din;
              cnt <= CW'(ADDR_WAIT);
            end else begin
              cnt <= CW'(DATA_WAIT);
            end
          end
        end
        default: begin
          // leave WAIT on the cen cycle where the count lands on zero
          if (cen) begin
            if (cnt <= CW'(1)) state <= S_IDLE;
            if (cnt != '0) cnt <= cnt - 1'b1;
          end
        end
      endcase
    end
  end

  // register writes take effect on the write clk, regardless of cen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) user_p[i] <= 8'd0;
      for (int i = 0; i < CH; i++) begin
        fnum_r[i] <= 9'd0;
        blk_r[i]  <= 3'd0;
        key_r[i]  <= 1'b0;
        sus_r[i]  <= 1'b0;
        inst_r[i] <= 4'd0;
        vol_r[i]  <= 4'd0;
      end
      rhy_en <= 1'b0;
      rhy_r  <= 5'd0;
    end else if (do_wr) begin
      if (lat[7:3] == 5'd0) begin
        user_p[lat[2:0]] <= bus.din;
      end else if (lat == 8'h0E) begin
        {rhy_en, rhy_r} <= bus.din[5:0];
      end else if (chan_ok) begin
        case (lat[7:4])
          4'h1: fnum_r[chan][7:0] <= bus.din;
          4'h2: {sus_r[chan], key_r[chan], blk_r[chan], fnum_r[chan][8]} <= bus.din[5:0];
          4'h3: {inst_r[chan], vol_r[chan]} <= bus.din;
          default: ;
        endcase
      end
    end
  end

  // patch RAM is not reset; prog writes beyond the last drum patch are ignored
  always_ff @(posedge clk) begin
    if (prog_we && (int'(prog_addr) < RAMSZ)) ram[RAW'(prog_addr)] <= prog_data;
  end

  logic       rhy_slot;
  logic       drum;
  int         psel;
  int         idx;
  logic [7:0] pb [8];

  assign rhy_slot = rhy_en && (CH >= 9) && (ch >= 4'd6) && (ch <= 4'd8);

  always_comb begin
    psel = 0;
    idx  = 0;
    // drum patches follow the melodic ones: ch6 op0/op1, ch7 op0/op1, ch8 op0/op1
    if (rhy_slot) psel = NPATCH + 1 + 2 * (int'(ch) - 6) + int'(op);
    else          psel = int'(inst_r[ch]);
    for (int b = 0; b < 8; b++) begin
      pb[b] = 8'd0;
      if (psel == 0) begin
        pb[b] = user_p[b];
      end else begin
        idx = (psel - 1) * 8 + b;
        if (idx < RAMSZ) pb[b] = ram[RAW'(idx)];
      end
    end
  end

  always_comb begin
    drum = 1'b0;
    if (rhy_slot) begin
      case (ch)
        4'd6:    drum = rhy_r[4];
        4'd7:    drum = op ? rhy_r[3] : rhy_r[0];
        4'd8:    drum = op ? rhy_r[1] : rhy_r[2];
        default: drum = 1'b0;
      endcase
    end
  end

  assign fnum   = fnum_r[ch];
  assign block  = blk_r[ch];
  assign sus_en = sus_r[ch];
  assign vol    = vol_r[ch];
  assign keyon  = key_r[ch] | drum;

  // carrier slots have no total level or feedback of their own
  assign opcfg = op ? {pb[1], pb[3][7:6], 6'd0, pb[3][4], 3'd0, pb[5], pb[7]}
                    : {pb[0], pb[2][7:6], pb[2][5:0], pb[3][3], pb[3][2:0], pb[4], pb[6]};

endmodule

// File: tb/tb_jtopll_regbank.sv
module tb_jtopll_regbank;
  localparam int CH        = 9;
  localparam int NPATCH    = 15;
  localparam int NP        = NPATCH + 6;
  localparam int ADDR_WAIT = 12;
  localparam int DATA_WAIT = 84;

  logic        clk = 1'b0;
  logic        rst, cen, prog_we;
  logic [7:0]  prog_addr, prog_data;

  logic        zero, op, keyon, sus_en, rhy_en;
  logic [3:0]  ch, vol;
  logic [8:0]  fnum;
  logic [2:0]  block;
  logic [35:0] opcfg;

  logic        zero2, op2, keyon2, sus_en2, rhy_en2;
  logic [3:0]  ch2, vol2;
  logic [8:0]  fnum2;
  logic [2:0]  block2;
  logic [35:0] opcfg2;

  jtopll_regbank_if bus ();
  jtopll_regbank_if bus2 ();

  assign bus2.wr   = bus.wr;
  assign bus2.addr = bus.addr;
  assign bus2.din  = bus.din;

  always #5 clk = ~clk;

  jtopll_regbank #(.CH(CH)) u_dut (
    .clk(clk), .rst(rst), .cen(cen), .bus(bus),
    .zero(zero), .ch(ch), .op(op), .fnum(fnum), .block(block), .keyon(keyon),
    .sus_en(sus_en), .vol(vol), .rhy_en(rhy_en), .opcfg(opcfg),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_we(prog_we)
  );

  jtopll_regbank #(.CH(12)) u_dut12 (
    .clk(clk), .rst(rst), .cen(cen), .bus(bus2),
    .zero(zero2), .ch(ch2), .op(op2), .fnum(fnum2), .block(block2), .keyon(keyon2),
    .sus_en(sus_en2), .vol(vol2), .rhy_en(rhy_en2), .opcfg(opcfg2),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_we(prog_we)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model
  int         slot;
  bit         m_busy, m_drop;
  int         m_cnt;
  logic [7:0] m_lat;
  logic [7:0] m_user [8];
  logic [7:0] m_ram  [NP+1][8];
  logic [8:0] m_fnum [CH];
  logic [2:0] m_blk  [CH];
  bit         m_key  [CH];
  bit         m_sus  [CH];
  logic [3:0] m_inst [CH];
  logic [3:0] m_vol  [CH];
  bit         m_rhy_en, m_bd, m_sd, m_tom, m_cy, m_hh;

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    slot = 0; m_busy = 0; m_drop = 0; m_cnt = 0; m_lat = 8'd0;
    for (int i = 0; i < 8; i++) m_user[i] = 8'd0;
    for (int i = 0; i < CH; i++) begin
      m_fnum[i] = 9'd0; m_blk[i] = 3'd0; m_key[i] = 0; m_sus[i] = 0;
      m_inst[i] = 4'd0; m_vol[i] = 4'd0;
    end
    m_rhy_en = 0; m_bd = 0; m_sd = 0; m_tom = 0; m_cy = 0; m_hh = 0;
  endtask

  task automatic model_write(input logic [7:0] d);
    int a, c;
    a = int'(m_lat);
    c = a % 16;
    if (a < 8) m_user[a] = d;
    else if (a == 14) {m_rhy_en, m_bd, m_sd, m_tom, m_cy, m_hh} = d[5:0];
    else if (a >= 16 && a < 64 && c < CH) begin
      if (a / 16 == 1) m_fnum[c][7:0] = d;
      else if (a / 16 == 2) begin
        m_sus[c] = d[5]; m_key[c] = d[4]; m_blk[c] = d[3:1]; m_fnum[c][8] = d[0];
      end else begin
        m_inst[c] = d[7:4]; m_vol[c] = d[3:0];
      end
    end
  endtask

  task automatic check_all();
    int c, p;
    bit o, rhy, dbit;
    logic [7:0]  b [8];
    logic [35:0] exp_cfg;
    c = slot / 2;
    o = (slot % 2) == 1;
    rhy = m_rhy_en && c >= 6 && c <= 8;
    p = rhy ? NPATCH + 1 + 2 * (c - 6) + int'(o) : int'(m_inst[c]);
    for (int k = 0; k < 8; k++) b[k] = (p == 0) ? m_user[k] : m_ram[p][k];
    if (o) exp_cfg = {b[1], b[3][7:6], 6'd0, b[3][4], 3'd0, b[5], b[7]};
    else   exp_cfg = {b[0], b[2][7:6], b[2][5:0], b[3][3], b[3][2:0], b[4], b[6]};
    dbit = 0;
    if (rhy) begin
      if (c == 6) dbit = m_bd;
      else if (c == 7) dbit = o ? m_sd : m_hh;
      else dbit = o ? m_cy : m_tom;
    end
    chk("ch", ch, c);
    chk("op", op, o);
    chk("zero", zero, (slot == 0));
    chk("busy", bus.busy, m_busy);
    chk("drop", bus.drop, m_drop);
    chk("fnum", fnum, m_fnum[c]);
    chk("block", block, m_blk[c]);
    chk("vol", vol, m_vol[c]);
    chk("sus_en", sus_en, m_sus[c]);
    chk("rhy_en", rhy_en, m_rhy_en);
    chk("keyon", keyon, m_key[c] | dbit);
    chk("opcfg", opcfg, exp_cfg);
  endtask

  task automatic step(input bit c);
    int pa;
    cen = c;
    @(posedge clk);
    m_drop = bus.wr && m_busy;
    if (m_busy) begin
      if (c) begin
        m_cnt--;
        if (m_cnt == 0) m_busy = 0;
      end
    end else if (bus.wr) begin
      if (!bus.addr) begin
        m_lat = bus.din;
        m_cnt = ADDR_WAIT;
      end else begin
        model_write(bus.din);
        m_cnt = DATA_WAIT;
      end
      m_busy = 1;
    end
    pa = int'(prog_addr);
    if (prog_we && pa < NP * 8) m_ram[pa / 8 + 1][pa % 8] = prog_data;
    if (c) slot = (slot + 1) % (2 * CH);
    #1;
    bus.wr = 1'b0;
    prog_we = 1'b0;
    check_all();
  endtask

  task automatic host_wr(input bit a, input logic [7:0] d);
    bus.addr = a;
    bus.din = d;
    bus.wr = 1'b1;
    step(1'($urandom % 2));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 1000 && m_busy; i++) step($urandom_range(0, 3) != 0);
  endtask

  task automatic goto_slot(input int s);
    for (int i = 0; i < 2 * CH && slot != s; i++) step(1'b1);
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
    host_wr(1'b0, a); wait_idle();
    host_wr(1'b1, d); wait_idle();
  endtask

  function automatic logic [7:0] pick_addr();
    case ($urandom % 6)
      0:       return 8'($urandom % 8);
      1:       return 8'h0E;
      2:       return 8'h10 + 8'($urandom % 16);
      3:       return 8'h20 + 8'($urandom % 16);
      4:       return 8'h30 + 8'($urandom % 16);
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int zc;
    rst = 1'b1; cen = 1'b0; prog_we = 1'b0; prog_addr = 8'd0; prog_data = 8'd0;
    bus.wr = 1'b0; bus.addr = 1'b0; bus.din = 8'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // load every built-in and drum patch, plus one out-of-range write
    for (int a = 0; a < NP * 8; a++) begin
      prog_we = 1'b1; prog_addr = 8'(a); prog_data = 8'($urandom);
      step(1'b0);
    end
    prog_we = 1'b1; prog_addr = 8'(NP * 8 + 3); prog_data = 8'hFF;
    step(1'b0);

    // sequencer: one full rotation, zero exactly once
    zc = 0;
    for (int i = 0; i < 2 * CH; i++) begin
      step(1'b1);
      if (zero === 1'b1) zc++;
    end
    chk("zero_per_rotation", zc, 1);

    // addr 0x30 then data 0x5A, with a dropped write in the middle of the data wait
    host_wr(1'b0, 8'h30); wait_idle();
    host_wr(1'b1, 8'h5A);
    repeat (10) step(1'b1);
    host_wr(1'b1, 8'hFF);
    wait_idle();
    goto_slot(0);
    chk("inst5_vol", vol, 4'hA);

    // random traffic with frequent writes while busy
    for (int i = 0; i < 4000; i++) begin
      if ($urandom % 6 == 0) begin
        bus.wr = 1'b1;
        bus.addr = 1'($urandom % 2);
        bus.din = bus.addr ? 8'($urandom) : pick_addr();
      end
      step($urandom % 4 != 0);
    end
    wait_idle();

    // rhythm: HH only, channel 7 key off
    write_reg(8'h27, 8'h00);
    write_reg(8'h0E, 8'h21);
    goto_slot(14);
    chk("hh_keyon", keyon, 1'b1);
    step(1'b1);
    chk("sd_keyon_off", keyon, 1'b0);

    // user patch byte 2 on channel 0
    write_reg(8'h30, 8'h00);
    write_reg(8'h02, 8'hC7);
    goto_slot(0);
    chk("mod_ksl", opcfg[27:26], 2'd3);
    chk("mod_tl", opcfg[25:20], 6'd7);
    step(1'b1);
    chk("car_tl", opcfg[25:20], 6'd0);

    // 0x19: out of range at CH=9, channel 9 at CH=12
    write_reg(8'h19, 8'hAB);
    for (int i = 0; i < 40 && ch2 != 4'd9; i++) step(1'b1);
    chk("ch12_reach9", ch2, 4'd9);
    chk("ch12_fnum9", fnum2[7:0], 8'hAB);

    // reset in the middle of a wait
    host_wr(1'b0, 8'h10);
    repeat (3) step(1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("busy_async_rst", bus.busy, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all();
    write_reg(8'h31, 8'h3C);
    goto_slot(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
